// File: rtl/muldiv_sequencer.sv
// Iterative 32x32 unsigned multiply / divide sequencer driving a shared external ALU.
// Define MULDIV_DIV_EN to build the divide datapath; otherwise DIV requests complete as illegal.
module muldiv_sequencer (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_lo,
  output logic [31:0] resp_hi,
  output logic        resp_illegal,
  output logic [31:0] seq_alu_a,
  output logic [31:0] seq_alu_b,
  output logic [3:0]  seq_alu_opcode,
  input  logic [31:0] seq_alu_result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  state_t      state_q;
  logic [5:0]  cnt_q;
  // hi/lo hold acc_hi/acc_lo for MUL and rem/quo for DIV; opnd is mcand or dvsr
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] opnd_q;
  logic [31:0] mul_sum;
  logic        mul_carry;
`ifdef MULDIV_DIV_EN
  logic        op_q;
  logic [31:0] div_t;
  logic        div_ge;
`endif

  assign resp_lo = lo_q;
  assign resp_hi = hi_q;

  always_comb begin
    mul_sum        = lo_q[0] ? seq_alu_result : hi_q;
    mul_carry      = lo_q[0] && (seq_alu_result < hi_q);
`ifdef MULDIV_DIV_EN
    div_t          = {hi_q[30:0], lo_q[31]};
    div_ge         = hi_q[31] || (div_t >= opnd_q);
`endif
    seq_alu_a      = '0;
    seq_alu_b      = '0;
    seq_alu_opcode = ALU_ADD;
    if (state_q == RUN) begin
`ifdef MULDIV_DIV_EN
      if (op_q) begin
        seq_alu_a      = div_t;
        seq_alu_b      = opnd_q;
        seq_alu_opcode = ALU_SUB;
      end else begin
        seq_alu_a      = hi_q;
        seq_alu_b      = opnd_q;
      end
`else
      seq_alu_a = hi_q;
      seq_alu_b = opnd_q;
`endif
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= IDLE;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_illegal <= 1'b0;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      opnd_q       <= '0;
`ifdef MULDIV_DIV_EN
      op_q         <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            cnt_q        <= '0;
            resp_illegal <= 1'b0;
            req_ready    <= 1'b0;
            if (!req_op) begin
              hi_q    <= '0;
              lo_q    <= req_b;
              opnd_q  <= req_a;
              state_q <= RUN;
`ifdef MULDIV_DIV_EN
              op_q    <= 1'b0;
`endif
            end else begin
`ifdef MULDIV_DIV_EN
              op_q   <= 1'b1;
              opnd_q <= req_b;
              if (req_b == '0) begin
                lo_q       <= '1;
                hi_q       <= req_a;
                resp_valid <= 1'b1;
                state_q    <= DONE;
              end else begin
                lo_q    <= req_a;
                hi_q    <= '0;
                state_q <= RUN;
              end
`else
              lo_q         <= '0;
              hi_q         <= '0;
              resp_illegal <= 1'b1;
              resp_valid   <= 1'b1;
              state_q      <= DONE;
`endif
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 6'd1;
`ifdef MULDIV_DIV_EN
          if (op_q) begin
            hi_q <= div_ge ? seq_alu_result : div_t;
            lo_q <= {lo_q[30:0], div_ge};
          end else begin
            {hi_q, lo_q} <= {mul_carry, mul_sum, lo_q[31:1]};
          end
`else
          {hi_q, lo_q} <= {mul_carry, mul_sum, lo_q[31:1]};
`endif
          if (cnt_q == 6'd31) begin
            resp_valid <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

endmodule
